// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if
//   Peripheral-bus connection between a bus master and the interrupt
//   controller register window. The same select/ready handshake is used by
//   the systick block.
//
//   select  master->slave  access request, address already decoded
//   wstrb   master->slave  byte write strobes; 4'b0000 means read
//   addr    master->slave  byte offset inside the window
//   data_i  master->slave  write data
//   ready   slave->master  one-cycle access acknowledge
//   data_o  slave->master  read data, valid while ready=1
// ---------------------------------------------------------------------------
interface irq_ctrl_if;
    logic        select;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;

    modport master (
        output select, wstrb, addr, data_i,
        input  ready, data_o
    );

    modport slave (
        input  select, wstrb, addr, data_i,
        output ready, data_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//   Memory-mapped interrupt controller. Each source has a pending latch that
//   is set by its synchronised request (edge or level mode), by a FORCE write,
//   and cleared by a write-1-to-clear on PENDING. The registered OR of
//   PENDING & ENABLE drives the single CPU interrupt line.
//
//   Register map (addr[3:2]):
//     0 ENABLE  RW    interrupt mask
//     1 PENDING R/W1C pending latches
//     2 STATUS  RO    PENDING & ENABLE
//     3 FORCE   WO    writing 1 sets the matching pending bit; reads 0
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      peripheral-bus slave (select/wstrb/addr/data_i/ready/data_o)
//     irq_src  asynchronous interrupt requests, bit 0 = systick
//     irq_o    registered combined interrupt to the CPU
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int                 NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    irq_ctrl_if.slave          bus,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        REG_ENABLE  = 2'd0,
        REG_PENDING = 2'd1,
        REG_STATUS  = 2'd2,
        REG_FORCE   = 2'd3
    } reg_e;

    state_e             state_q, state_d;
    logic               commit;

    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_IRQ-1:0] hw_set, w1c_clr, force_set, wr_mask, wr_bits;
    logic               irq_q, irq_d;
    logic               ready_q;
    logic [31:0]        rdata_q, rdata_d, rd_word;
    logic [31:0]        lane_mask;
    logic               is_write;
    reg_e               reg_sel;
    logic               unused_bits;

    assign is_write  = |bus.wstrb;
    assign reg_sel   = reg_e'(bus.addr[3:2]);
    assign lane_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                        {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
    assign wr_mask   = lane_mask[NUM_IRQ-1:0];
    assign wr_bits   = bus.data_i[NUM_IRQ-1:0] & wr_mask;

    // Byte offset bits and write-data/lane bits above NUM_IRQ carry no state.
    assign unused_bits = ^{bus.addr[1:0], bus.data_i, lane_mask};

    // -----------------------------------------------------------------------
    // Bus handshake: one RESP cycle per select assertion. HOLD absorbs a
    // master that keeps select high so it never sees a second ready.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.select) state_d = ST_RESP;
            ST_RESP: begin
                commit  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: if (!bus.select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file next-state and read mux.
    // -----------------------------------------------------------------------
    always_comb begin
        enable_d  = enable_q;
        w1c_clr   = '0;
        force_set = '0;
        if (commit && is_write) begin
            unique case (reg_sel)
                REG_ENABLE:  enable_d  = (enable_q & ~wr_mask) | wr_bits;
                REG_PENDING: w1c_clr   = wr_bits;
                REG_FORCE:   force_set = wr_bits;
                default:     ;  // STATUS is read-only; write still acknowledged
            endcase
        end

        // Edge sources fire on s2 & ~s3; level sources fire while s2 is high.
        hw_set = sync2_q & (~sync3_q | ~EDGE_MASK);

        // Setting takes priority over a simultaneous W1C clear, so a still
        // asserted level source cannot be lost.
        pending_d = (pending_q & ~w1c_clr) | hw_set | force_set;

        rd_word = '0;
        unique case (reg_sel)
            REG_ENABLE:  rd_word = 32'(enable_q);
            REG_PENDING: rd_word = 32'(pending_q);
            REG_STATUS:  rd_word = 32'(pending_q & enable_q);
            default:     rd_word = '0;
        endcase

        rdata_d = (commit && !is_write) ? rd_word : rdata_q;
        irq_d   = |(pending_q & enable_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            enable_q  <= '0;
            pending_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            sync1_q   <= irq_src;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            irq_q     <= irq_d;
            ready_q   <= commit;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.data_o = rdata_q;
    assign irq_o      = irq_q;

endmodule
